// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit that sits beside the 4x16 register file.
// A launch captures the operands, then runs WIDTH shift-add or restoring
// shift-subtract iterations. It then presents the result for one DONE cycle,
// which drives the register file write port.
// Build option: define MULDIV_SIGNED_EN for two's complement operands. This
// adds a FIX cycle that restores the sign of the result.
module mul_div_unit #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic                  Op,
  input  logic [REG_ADDR_W-1:0] Dest,
  input  logic [WIDTH-1:0]      OperandA,
  input  logic [WIDTH-1:0]      OperandB,
  output logic                  Busy,
  output logic                  Done,
  output logic [WIDTH-1:0]      ResultData,
  output logic [REG_ADDR_W-1:0] ResultDest,
  output logic                  ResultWrite,
  output logic                  DivZero
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef MULDIV_SIGNED_EN
    FIX  = 2'd3,
`endif
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      count;

  // Launch-time operation context and working registers.
  // x: multiplier (mul) or dividend shifting into quotient (div).
  // y: multiplicand shifting left (mul) or divisor (div).
  // acc: product (mul) or partial remainder (div).
  logic                  op_q;
  logic                  divzero_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [WIDTH-1:0]      x, y, acc;
  logic [WIDTH-1:0]      x_nx, y_nx, acc_nx;
  logic [WIDTH:0]        r_shift, trial;
`ifdef MULDIV_SIGNED_EN
  logic                  neg_q;

  // Two's complement negate when neg is set; also yields operand magnitudes.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction
`endif

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    x_nx    = x;
    y_nx    = y;
    acc_nx  = acc;
    r_shift = '0;
    trial   = '0;
    if (op_q) begin
      r_shift = {acc, x[WIDTH-1]};
      trial   = r_shift - {1'b0, y};
      if (!trial[WIDTH]) begin
        acc_nx = trial[WIDTH-1:0];
        x_nx   = {x[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = r_shift[WIDTH-1:0];
        x_nx   = {x[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (x[0]) acc_nx = acc + y;
      y_nx = y << 1;
      x_nx = x >> 1;
    end
  end

  // Datapath: capture operands at launch, iterate while running.
  always_ff @(posedge Clock) begin
    if (state == IDLE && Start) begin
      op_q      <= Op;
      dest_q    <= Dest;
      divzero_q <= Op && (OperandB == '0);
      acc       <= '0;
`ifdef MULDIV_SIGNED_EN
      x         <= cond_neg(OperandA, OperandA[WIDTH-1]);
      y         <= cond_neg(OperandB, OperandB[WIDTH-1]);
      neg_q     <= OperandA[WIDTH-1] ^ OperandB[WIDTH-1];
`else
      x         <= OperandA;
      y         <= OperandB;
`endif
    end else if (state == RUN) begin
      x   <= x_nx;
      y   <= y_nx;
      acc <= acc_nx;
    end
  end

  // Control FSM with registered outputs; a reset aborts any operation in flight.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      count       <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      ResultWrite <= 1'b0;
      DivZero     <= 1'b0;
      ResultData  <= '0;
      ResultDest  <= '0;
    end else begin
      Done        <= 1'b0;
      ResultWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state <= RUN;
            count <= '0;
            Busy  <= 1'b1;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == LAST) begin
`ifdef MULDIV_SIGNED_EN
            state <= FIX;
`else
            state       <= DONE;
            Done        <= 1'b1;
            ResultWrite <= (dest_q != '0);
            ResultDest  <= dest_q;
            DivZero     <= divzero_q;
            ResultData  <= divzero_q ? '1 : (op_q ? x_nx : acc_nx);
`endif
          end
        end
`ifdef MULDIV_SIGNED_EN
        FIX: begin
          state       <= DONE;
          Done        <= 1'b1;
          ResultWrite <= (dest_q != '0);
          ResultDest  <= dest_q;
          DivZero     <= divzero_q;
          ResultData  <= divzero_q ? '1 : cond_neg(op_q ? x : acc, neg_q);
        end
`endif
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed operations with a queue of
// expected results that is popped when Done is observed.
// Honours MULDIV_SIGNED_EN to match the build under test.
module tb_mul_div_unit;

  localparam int WIDTH = 16;
`ifdef MULDIV_SIGNED_EN
  localparam int LAT = WIDTH + 1;
`else
  localparam int LAT = WIDTH;
`endif

  logic        Clock;
  logic        ResetN;
  logic        Start;
  logic        Op;
  logic [1:0]  Dest;
  logic [15:0] OperandA;
  logic [15:0] OperandB;
  logic        Busy;
  logic        Done;
  logic [15:0] ResultData;
  logic [1:0]  ResultDest;
  logic        ResultWrite;
  logic        DivZero;

  mul_div_unit #(.WIDTH(16), .REG_ADDR_W(2)) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .Start      (Start),
    .Op         (Op),
    .Dest       (Dest),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .Busy       (Busy),
    .Done       (Done),
    .ResultData (ResultData),
    .ResultDest (ResultDest),
    .ResultWrite(ResultWrite),
    .DivZero    (DivZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  dest;
    logic        wr;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
`ifdef MULDIV_SIGNED_EN
    int sa, sb_;
    sa  = $signed(a);
    sb_ = $signed(b);
    if (op) begin
      if (b == 16'h0000) return 16'hFFFF;
      p = 32'(sa / sb_);
    end else begin
      p = 32'(sa * sb_);
    end
`else
    if (op) begin
      if (b == 16'h0000) return 16'hFFFF;
      p = {16'd0, a / b};
    end else begin
      p = {16'd0, a} * {16'd0, b};
    end
`endif
    return p[15:0];
  endfunction

  // Launch one operation, optionally disturbing Start/operands while busy, and check it.
  task automatic run_op(input string tag, input logic op, input logic [1:0] dest,
                        input logic [15:0] a, input logic [15:0] b, input bit junk);
    exp_t e;
    int   done_k;
    int   busy_drop;
    e.data = model(op, a, b);
    e.dest = dest;
    e.wr   = (dest != 2'd0);
    e.dz   = op && (b == 16'h0000);
    sb.push_back(e);
    @(negedge Clock);
    Start = 1'b1; Op = op; Dest = dest; OperandA = a; OperandB = b;
    @(posedge Clock); #1;
    Start = 1'b0;
    if (junk) begin
      Op = ~op; Dest = ~dest; OperandA = 16'hAAAA; OperandB = 16'h0003;
    end
    check({tag, "_busy_e0"}, 32'(Busy), 32'd1);
    done_k    = -1;
    busy_drop = 0;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(negedge Clock);
      Start = junk && (k == 5);
      @(posedge Clock); #1;
      if (Done) begin
        done_k = k;
        break;
      end
      if (!Busy) busy_drop++;
    end
    check({tag, "_latency"}, 32'(done_k), 32'(LAT));
    check({tag, "_busy_run"}, 32'(busy_drop), 32'd0);
    check({tag, "_busy_done"}, 32'(Busy), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, 32'(ResultData), 32'(e.data));
      check({tag, "_dest"}, 32'(ResultDest), 32'(e.dest));
      check({tag, "_write"}, 32'(ResultWrite), 32'(e.wr));
      check({tag, "_divzero"}, 32'(DivZero), 32'(e.dz));
    end
    // DONE -> IDLE edge, with a stray Start in DONE when disturbing
    @(negedge Clock);
    if (junk) begin
      Start = 1'b1; OperandA = 16'h5555; OperandB = 16'h0009;
    end
    @(posedge Clock); #1;
    Start = 1'b0;
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
    check({tag, "_idle"}, 32'(Busy), 32'd0);
    check({tag, "_hold"}, 32'(ResultData), 32'(e.data));
  endtask

  initial begin
    int done_cnt;
    ResetN = 1'b0; Start = 1'b0; Op = 1'b0; Dest = 2'd0;
    OperandA = 16'h0000; OperandB = 16'h0000;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_write", 32'(ResultWrite), 32'd0);
    check("rst_divzero", 32'(DivZero), 32'd0);
    check("rst_data", 32'(ResultData), 32'd0);
    check("rst_dest", 32'(ResultDest), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;

    run_op("mul_7x9", 1'b0, 2'd2, 16'h0007, 16'h0009, 1'b0);
    run_op("div_100_7", 1'b1, 2'd1, 16'h0064, 16'h0007, 1'b0);
    run_op("div_by_0", 1'b1, 2'd3, 16'h1234, 16'h0000, 1'b0);
    run_op("mul_trunc_r0", 1'b0, 2'd0, 16'h0100, 16'h0100, 1'b0);
    run_op("mul_big", 1'b0, 2'd1, 16'h1234, 16'h0011, 1'b0);
    run_op("div_max", 1'b1, 2'd2, 16'hFFFF, 16'h0001, 1'b0);
    run_op("ignore_start", 1'b0, 2'd2, 16'h0005, 16'h0006, 1'b1);
    run_op("back_to_back", 1'b1, 2'd3, 16'h0200, 16'h0010, 1'b0);

    // Abort an operation with reset at E8
    @(negedge Clock);
    Start = 1'b1; Op = 1'b0; Dest = 2'd2; OperandA = 16'h0003; OperandB = 16'h0005;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (8) @(posedge Clock);
    #1 ResetN = 1'b0;
    #1;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_data", 32'(ResultData), 32'd0);
    check("abort_dest", 32'(ResultDest), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    done_cnt = 0;
    repeat (LAT + 4) begin
      @(posedge Clock); #1;
      if (Done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle", 32'(Busy), 32'd0);
    run_op("after_reset", 1'b0, 2'd2, 16'h0003, 16'h0005, 1'b0);

`ifdef MULDIV_SIGNED_EN
    run_op("smul_neg", 1'b0, 2'd1, 16'hFFFD, 16'h0004, 1'b0);
    run_op("sdiv_neg", 1'b1, 2'd2, 16'hFF9C, 16'h0007, 1'b0);
    run_op("sdiv_min", 1'b1, 2'd3, 16'h8000, 16'hFFFF, 1'b0);
    run_op("sdiv_zero", 1'b1, 2'd1, 16'hFF9C, 16'h0000, 1'b0);
    run_op("sdiv_both", 1'b1, 2'd1, 16'hFF9C, 16'hFFF9, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
